cnn_layer_accel_synch_resp: RTL and testbench
=============================================

# cnn_layer_accel_synch_resp

Core-side responder for the interface-to-core synchronization handshake of the CNN layer accelerator. It receives a toggle request with a bundled 2-bit command from the interface clock domain and synchronizes it into the core domain. It then sequences the command against the core pipeline (reset, flush, start, ping) and returns an acknowledge toggle. It sits at the core boundary, directly opposite the interface-domain synch initiator.

## Interface
- SYNC_STAGES, 2, flip-flop stages on req_tgl (legal 2..4)
- RST_CYCLES, 16, core_rst hold length in cycles (legal 1..255)
- TIMEOUT_CYCLES, 1024, max FLUSH wait for pipe_idle (macro-gated, legal 2..65535)

Ports:
- clk  in  1  core clock; all logic on posedge
- rst  in  1  synchronous, active-low reset
- req_tgl  in  1  request toggle from interface domain (asynchronous)
- req_cmd  in  2  bundled command, stable from req_tgl edge until ack_tgl edge; 0 SOFT_RST, 1 FLUSH, 2 START, 3 PING
- pipe_idle  in  1  core pipeline drained
- core_rst  out  1  active-high reset to core pipeline
- flush  out  1  level, pipeline flush request
- start  out  1  single-cycle start pulse
- ack_tgl  out  1  acknowledge toggle back to interface domain
- busy  out  1  high in any state other than IDLE
- proto_err  out  1  sticky, request edge seen while busy
- err_timeout  out  1  sticky, FLUSH timed out (macro-gated)

## Operation
- req_tgl passes through a SYNC_STAGES synchronizer, then one more flop. An XOR of the last two flops produces req_evt.
- States and transitions:
  - POR: core_rst=1; counts RST_CYCLES, then goes to IDLE.
  - IDLE: on req_evt, latch req_cmd into cmd_q and go to DECODE.
  - DECODE (1 cycle): SOFT_RST → RESET, FLUSH → FLUSH, START → START, PING → ACK.
  - RESET: core_rst=1 for RST_CYCLES, then ACK.
  - FLUSH: flush=1 until pipe_idle=1 is sampled, then ACK.
  - START: start=1 for one cycle, then ACK.
  - ACK: invert ack_tgl, then IDLE.
- Edge during any non-IDLE state (including POR): the request is dropped, proto_err is set, and no ack is issued for it.
- Counters are 8-bit (reset) and 16-bit (timeout). Each loads 0 on state entry and compares to PARAM-1.

## Timing
- Reset (rst=0) values: core_rst=1, flush=0, start=0, ack_tgl=0, busy=1, proto_err=0, err_timeout=0. All sync flops are 0. State is POR with counter 0.
- After rst rises, core_rst stays 1 for exactly RST_CYCLES cycles. IDLE (busy=0) follows on the next cycle.
- If req_tgl=1 at reset release, that counts as a request edge during POR: it is dropped and proto_err is set.
- A req_tgl edge reaches req_evt SYNC_STAGES+1 cycles later. req_cmd is sampled in the IDLE cycle where req_evt=1.
- Latency from req_evt to ack_tgl edge:
  - PING: 2 cycles.
  - START: 3 cycles; start is high in cycle 2.
  - SOFT_RST: RST_CYCLES+2 cycles.
  - FLUSH: (cycles until pipe_idle is sampled)+2. If pipe_idle is already 1 on entry, FLUSH lasts 1 cycle.
- flush is deasserted in the ACK cycle.
- rst asserted mid-operation: abort to POR immediately. ack_tgl returns to 0; the initiator must also be reset.
- req_evt in the ACK cycle is a protocol error.

## Configuration
- CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN defined:
  - A FLUSH lasting TIMEOUT_CYCLES cycles without pipe_idle sets err_timeout and goes to ACK with flush dropped.
  - err_timeout clears only on rst.
- Undefined: FLUSH waits indefinitely; the err_timeout port is absent, and the timeout counter and TIMEOUT_CYCLES logic are not built.

## Structure
- Shared package cnn_layer_accel_synch_pkg holds:
  - enum synch_cmd_t (SOFT_RST, FLUSH, START, PING)
  - enum synch_resp_state_t (POR, IDLE, DECODE, RESET, FLUSH, START, ACK)
  - SYNCH_CMD_W = 2
- The initiator imports the same package.
- One sub-module: cnn_layer_accel_bit_sync (parameterized SYNC_STAGES, reset-to-0 flop chain). It is reused wherever single bits cross into clk.

## Test plan
- Release rst, req_tgl=0, RST_CYCLES=16 → core_rst high for 16 cycles after release, busy falls 1 cycle later, ack_tgl=0.
- From IDLE, toggle req_tgl with cmd=PING → ack_tgl toggles exactly SYNC_STAGES+3 cycles after the edge, with no core_rst, flush or start activity.
- cmd=START → start is high for exactly 1 cycle, then ack_tgl toggles on the next cycle.
- cmd=FLUSH with pipe_idle held low 50 cycles, then high → flush high 50 cycles, ack_tgl toggles 2 cycles after pipe_idle is sampled high.
- With the macro defined and TIMEOUT_CYCLES=64, cmd=FLUSH with pipe_idle=0 → err_timeout sets after 64 cycles, flush drops, ack_tgl toggles.
- Toggle req_tgl twice, 2 cycles apart, with cmd=SOFT_RST → first request is serviced, proto_err=1, only one ack_tgl toggle. Then assert rst mid-RESET → all outputs return to reset values.

Source files
------------

// File: rtl/cnn_layer_accel_synch_pkg.sv
// Shared types for the CNN accelerator interface/core synch handshake.
// Imported by both the initiator and the responder.
package cnn_layer_accel_synch_pkg;

   localparam int SYNCH_CMD_W = 2;

   typedef enum logic [SYNCH_CMD_W-1:0] {
      CMD_SOFT_RST = 2'd0,
      CMD_FLUSH    = 2'd1,
      CMD_START    = 2'd2,
      CMD_PING     = 2'd3
   } synch_cmd_t;

   typedef enum logic [2:0] {
      ST_POR    = 3'd0,
      ST_IDLE   = 3'd1,
      ST_DECODE = 3'd2,
      ST_RESET  = 3'd3,
      ST_FLUSH  = 3'd4,
      ST_START  = 3'd5,
      ST_ACK    = 3'd6
   } synch_resp_state_t;

endpackage

// File: rtl/cnn_layer_accel_synch_resp_if.sv
// Handshake and core-control bundle of the synch responder.
// err_timeout exists only with CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN.
interface cnn_layer_accel_synch_resp_if;
   import cnn_layer_accel_synch_pkg::*;

   logic                   req_tgl;
   logic [SYNCH_CMD_W-1:0] req_cmd;
   logic                   pipe_idle;
   logic                   core_rst;
   logic                   flush;
   logic                   start;
   logic                   ack_tgl;
   logic                   busy;
   logic                   proto_err;
`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
   logic                   err_timeout;
`endif

   modport master (
      output req_tgl, req_cmd, pipe_idle,
`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
      input  err_timeout,
`endif
      input  core_rst, flush, start,
      input  ack_tgl, busy, proto_err
   );

   modport slave (
      input  req_tgl, req_cmd, pipe_idle,
`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
      output err_timeout,
`endif
      output core_rst, flush, start,
      output ack_tgl, busy, proto_err
   );

endinterface

// File: rtl/cnn_layer_accel_bit_sync.sv
// Reset-to-0 flop chain bringing a single bit into the clk domain.
module cnn_layer_accel_bit_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cnn_layer_accel_synch_resp.sv
// Core-side synch responder: syncs req toggle, sequences command, acks.
// Optional FLUSH timeout: CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN.
module cnn_layer_accel_synch_resp
   import cnn_layer_accel_synch_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int RST_CYCLES     = 16
`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input logic                         clk,
   input logic                         rst,
   cnn_layer_accel_synch_resp_if.slave bus
);

   localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

   synch_resp_state_t state_q, state_d;
   synch_cmd_t        cmd_q, cmd_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              ack_q, ack_d;
   logic              perr_q, perr_d;
   logic              req_sync, req_dly_q, req_evt;

   cnn_layer_accel_bit_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_req_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.req_tgl),
      .q_o (req_sync)
   );

   assign req_evt = req_sync ^ req_dly_q;

`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tcnt_q, tcnt_d;
   logic        terr_q, terr_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tcnt_q <= '0;
         terr_q <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         terr_q <= terr_d;
      end
   end

   assign bus.err_timeout = terr_q;
`endif

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      cnt_d   = '0;
      ack_d   = ack_q;
      perr_d  = perr_q | (req_evt && state_q != ST_IDLE);
`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
      tcnt_d  = '0;
      terr_d  = terr_q;
`endif
      unique case (state_q)
         ST_POR: begin
            if (cnt_q == RST_LAST) state_d = ST_IDLE;
            else                   cnt_d   = cnt_q + 8'd1;
         end
         ST_IDLE: begin
            if (req_evt) begin
               cmd_d   = synch_cmd_t'(bus.req_cmd);
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            unique case (cmd_q)
               CMD_SOFT_RST: state_d = ST_RESET;
               CMD_FLUSH:    state_d = ST_FLUSH;
               CMD_START:    state_d = ST_START;
               CMD_PING:     state_d = ST_ACK;
               default:      state_d = ST_ACK;
            endcase
         end
         ST_RESET: begin
            if (cnt_q == RST_LAST) state_d = ST_ACK;
            else                   cnt_d   = cnt_q + 8'd1;
         end
         ST_FLUSH: begin
            if (bus.pipe_idle) begin
               state_d = ST_ACK;
`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
            end else if (tcnt_q == TO_LAST) begin
               terr_d  = 1'b1;
               state_d = ST_ACK;
            end else begin
               tcnt_d  = tcnt_q + 16'd1;
`endif
            end
         end
         ST_START: state_d = ST_ACK;
         ST_ACK: begin
            ack_d   = ~ack_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_POR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_POR;
         cmd_q     <= CMD_SOFT_RST;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         perr_q    <= 1'b0;
         req_dly_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         perr_q    <= perr_d;
         req_dly_q <= req_sync;
      end
   end

   assign bus.core_rst  = (state_q == ST_POR) || (state_q == ST_RESET);
   assign bus.flush     = (state_q == ST_FLUSH);
   assign bus.start     = (state_q == ST_START);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.ack_tgl   = ack_q;
   assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_cnn_layer_accel_synch_resp.sv
// Self-checking bench for the synch responder against a latency model.
module tb_cnn_layer_accel_synch_resp;
   import cnn_layer_accel_synch_pkg::*;

   localparam int S   = 2;
   localparam int RST = 16;
`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
   localparam int TO  = 64;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   logic exp_ack = 1'b0;

   cnn_layer_accel_synch_resp_if bus ();

`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
   cnn_layer_accel_synch_resp #(
      .SYNC_STAGES(S),
      .RST_CYCLES(RST),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`else
   cnn_layer_accel_synch_resp #(
      .SYNC_STAGES(S),
      .RST_CYCLES(RST)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`endif

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input int got,
                        input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d",
                    tag, got, exp);
   endtask

   // Edge driven right after P0; pipe_idle rises right after P_d.
   task automatic model(input int cmd, input int d,
                        output int lat, output int n_st,
                        output int n_fl, output int n_rs,
                        output int tmo);
      int f;
      lat = S + 3; n_st = 0; n_fl = 0;
      n_rs = 0; tmo = 0;
      case (cmd)
         0: begin
            lat  = S + 3 + RST;
            n_rs = RST;
         end
         1: begin
            f = (d + 1 > S + 3) ? d + 1 : S + 3;
            f = f - (S + 2);
`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
            if (f > TO) begin
               f   = TO;
               tmo = 1;
            end
`endif
            lat  = S + 3 + f;
            n_fl = f;
         end
         2: begin
            lat  = S + 4;
            n_st = 1;
         end
         default: lat = S + 3;
      endcase
   endtask

   task automatic run_req(input int cmd, input int d);
      int k, lat, e_lat, e_st, e_fl, e_rs, e_to;
      int n_st, n_fl, n_rs;
      logic a0;
      a0 = bus.ack_tgl;
      bus.req_cmd   = 2'(cmd);
      bus.req_tgl   = ~bus.req_tgl;
      bus.pipe_idle = (d == 0);
      k = 0; lat = -1;
      n_st = 0; n_fl = 0; n_rs = 0;
      while (k < 400 && lat < 0) begin
         @(posedge clk); #1;
         k++;
         if (k == d) bus.pipe_idle = 1'b1;
         if (bus.start)    n_st++;
         if (bus.flush)    n_fl++;
         if (bus.core_rst) n_rs++;
         if (bus.ack_tgl != a0) lat = k;
      end
      model(cmd, d, e_lat, e_st, e_fl, e_rs, e_to);
      exp_ack = ~exp_ack;
      check($sformatf("lat_c%0d", cmd), lat, e_lat);
      check("start_cyc", n_st, e_st);
      check("flush_cyc", n_fl, e_fl);
      check("rst_cyc", n_rs, e_rs);
      check("ack", int'(bus.ack_tgl), int'(exp_ack));
      check("busy", int'(bus.busy), 0);
`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
      check("err_to", int'(bus.err_timeout), e_to);
`endif
   endtask

   task automatic chk_reset_vals();
      check("rv_core_rst", int'(bus.core_rst), 1);
      check("rv_flush", int'(bus.flush), 0);
      check("rv_start", int'(bus.start), 0);
      check("rv_ack", int'(bus.ack_tgl), 0);
      check("rv_busy", int'(bus.busy), 1);
      check("rv_perr", int'(bus.proto_err), 0);
`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
      check("rv_err_to", int'(bus.err_timeout), 0);
`endif
   endtask

   initial begin
      int n, acks;
      logic a0;
      bus.req_tgl   = 1'b0;
      bus.req_cmd   = 2'd0;
      bus.pipe_idle = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals();

      // Reset release: count core_rst cycles.
      rst = 1'b1;
      n = 0;
      while (bus.core_rst && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      check("por_len", n, RST);
      check("por_busy", int'(bus.busy), 0);
      check("por_ack", int'(bus.ack_tgl), 0);

      run_req(int'(CMD_PING), 0);
      run_req(int'(CMD_START), 3);
      run_req(int'(CMD_FLUSH), S + 51);
      run_req(int'(CMD_FLUSH), 0);
      run_req(int'(CMD_SOFT_RST), 5);

      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 4)) begin
            @(posedge clk); #1;
         end
         run_req(int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 60)));
      end
      check("perr_clean", int'(bus.proto_err), 0);

`ifdef CNN_LAYER_ACCEL_SYNCH_TIMEOUT_EN
      run_req(int'(CMD_FLUSH), 1000);
`endif

      // Second edge two cycles later must be dropped.
      a0 = bus.ack_tgl;
      bus.req_cmd = 2'(CMD_SOFT_RST);
      bus.req_tgl = ~bus.req_tgl;
      repeat (2) begin
         @(posedge clk); #1;
      end
      bus.req_tgl = ~bus.req_tgl;
      acks = 0;
      for (int k = 3; k <= S + RST + 40; k++) begin
         @(posedge clk); #1;
         if (bus.ack_tgl != a0) begin
            acks++;
            a0 = bus.ack_tgl;
         end
      end
      exp_ack = ~exp_ack;
      check("dbl_acks", acks, 1);
      check("dbl_ack", int'(bus.ack_tgl), int'(exp_ack));
      check("dbl_perr", int'(bus.proto_err), 1);

      // Abort mid-RESET.
      bus.req_tgl = ~bus.req_tgl;
      repeat (S + 6) begin
         @(posedge clk); #1;
      end
      check("mid_core_rst", int'(bus.core_rst), 1);
      check("mid_busy", int'(bus.busy), 1);
      rst = 1'b0;
      bus.req_tgl = 1'b1;
      @(posedge clk); #1;
      chk_reset_vals();
      exp_ack = 1'b0;

      // req_tgl already high at release counts as a POR edge.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (RST + 6) begin
         @(posedge clk); #1;
      end
      check("porev_perr", int'(bus.proto_err), 1);
      check("porev_ack", int'(bus.ack_tgl), 0);
      check("porev_busy", int'(bus.busy), 0);
      run_req(int'(CMD_PING), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
